// File: rtl/text_writer.sv
// text_writer: byte-stream write controller for a DEPTH x 8 character memory.
// Keeps a cursor, turns each accepted byte into at most one memory write,
// and runs a full-memory clear sequence on form feed.
module text_writer #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned COLS  = 16,
    parameter logic [7:0]  FILL  = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_di,
    output logic [7:0] cursor
);

    localparam logic [7:0] LAST_ADDR  = 8'(DEPTH - 1);
    localparam logic [7:0] COLS8      = 8'(COLS);
    localparam logic [7:0] LAST_LINE  = 8'(DEPTH - COLS);

    localparam logic [7:0] CODE_BS    = 8'h08;
    localparam logic [7:0] CODE_CR    = 8'h0D;
    localparam logic [7:0] CODE_FF    = 8'h0C;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] cur_inc;
    logic [7:0] cur_dec;
    logic [7:0] line_base;
    logic [7:0] cur_cr;
    logic       printable;

    // Accept bytes only in IDLE and never while reset is asserted.
    assign in_ready = (state == IDLE) && !rst;

    // Cursor arithmetic with explicit wrap at DEPTH.
    assign cur_inc   = (cursor == LAST_ADDR) ? 8'd0 : cursor + 8'd1;
    assign cur_dec   = cursor - 8'd1;
    assign line_base = cursor - (cursor % COLS8);
    assign cur_cr    = (line_base == LAST_LINE) ? 8'd0 : line_base + COLS8;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    // Control FSM with registered memory port and cursor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cursor   <= 8'd0;
            mem_we   <= 1'b0;
            mem_addr <= 8'd0;
            mem_di   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (in_valid) begin
                        if (printable) begin
                            mem_we   <= 1'b1;
                            mem_addr <= cursor;
                            mem_di   <= in_data;
                            cursor   <= cur_inc;
                        end else if (in_data == CODE_BS) begin
                            if (cursor != 8'd0) begin
                                mem_we   <= 1'b1;
                                mem_addr <= cur_dec;
                                mem_di   <= FILL;
                                cursor   <= cur_dec;
                            end
                        end else if (in_data == CODE_CR) begin
                            cursor <= cur_cr;
                        end else if (in_data == CODE_FF) begin
                            // First clear write is issued straight from the accept.
                            state    <= CLEAR;
                            mem_we   <= 1'b1;
                            mem_addr <= 8'd0;
                            mem_di   <= FILL;
                            cursor   <= 8'd0;
                        end
                    end
                end
                CLEAR: begin
                    // mem_addr doubles as the clear pointer.
                    if (mem_addr == LAST_ADDR) begin
                        state  <= IDLE;
                        mem_we <= 1'b0;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= mem_addr + 8'd1;
                        mem_di   <= FILL;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Testbench for text_writer: directed scenarios with literal expectations
// plus randomized traffic, all checked cycle by cycle against a queue model.
module tb_text_writer;

    localparam int DEPTH = 128;
    localparam int COLS  = 16;
    localparam int FILL  = 8'h7E;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_di;
    logic [7:0] cursor;

    int tests = 0;
    int fails = 0;

    text_writer #(.DEPTH(DEPTH), .COLS(COLS), .FILL(8'h7E)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .cursor   (cursor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain cursor arithmetic and a queue of pending clear writes.
    int  m_cur;
    int  m_we, m_addr, m_di;
    bit  m_clr;
    bit  started = 0;
    int  pend[$];

    always @(negedge clk) begin
        bit ready;
        int b;
        ready = !rst && !m_clr;
        if (started) begin
            chk("in_ready", 32'(in_ready), 32'(ready));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_we != 0) chk("mem_di", 32'(mem_di), 32'(m_di));
            chk("cursor", 32'(cursor), 32'(m_cur));
        end
        if (rst) begin
            started = 1;
            m_cur = 0; m_we = 0; m_addr = 0; m_di = 0; m_clr = 0;
            pend.delete();
        end else if (started) begin
            if (pend.size() > 0) begin
                m_we = 1; m_addr = pend.pop_front(); m_di = FILL; m_clr = 1;
            end else begin
                m_clr = 0;
                m_we  = 0;
                if (in_valid && ready) begin
                    b = int'(in_data);
                    if (b >= 32 && b <= 126) begin
                        m_we = 1; m_addr = m_cur; m_di = b;
                        m_cur = (m_cur + 1) % DEPTH;
                    end else if (b == 8) begin
                        if (m_cur > 0) begin
                            m_cur = m_cur - 1;
                            m_we = 1; m_addr = m_cur; m_di = FILL;
                        end
                    end else if (b == 13) begin
                        m_cur = ((m_cur / COLS) + 1) * COLS % DEPTH;
                    end else if (b == 12) begin
                        for (int a = 1; a < DEPTH; a++) pend.push_back(a);
                        m_we = 1; m_addr = 0; m_di = FILL; m_clr = 1; m_cur = 0;
                    end
                end
            end
        end
    end

    // Present a byte and hold it until it transfers; returns at posedge+1 after the transfer.
    task automatic send(input logic [7:0] b);
        bit done = 0;
        @(posedge clk); #1;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL ready_timeout: in_ready stuck low");
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;

        // Reset then "AB"
        idle(2);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        send(8'h41);
        chk("a_we", 32'(mem_we), 32'd1);
        chk("a_addr", 32'(mem_addr), 32'd0);
        chk("a_di", 32'(mem_di), 32'h41);
        chk("a_ready", 32'(in_ready), 32'd1);
        send(8'h42);
        chk("b_we", 32'(mem_we), 32'd1);
        chk("b_addr", 32'(mem_addr), 32'd1);
        chk("b_di", 32'(mem_di), 32'h42);
        chk("b_cursor", 32'(cursor), 32'd2);

        // Wrap: clear to home the cursor, then 128 printables
        send(8'h0C);
        wait_ready();
        for (int i = 0; i < DEPTH; i++) send(8'h30);
        chk("wrap_addr", 32'(mem_addr), 32'd127);
        chk("wrap_cursor", 32'(cursor), 32'd0);
        send(8'h31);
        chk("wrap2_addr", 32'(mem_addr), 32'd0);
        chk("wrap2_di", 32'(mem_di), 32'h31);

        // Backspace
        send(8'h08);
        chk("bs1_addr", 32'(mem_addr), 32'd0);
        chk("bs1_di", 32'(mem_di), 32'h7E);
        send(8'h08);
        chk("bs0_we", 32'(mem_we), 32'd0);
        chk("bs0_cursor", 32'(cursor), 32'd0);
        send(8'h58); send(8'h59); send(8'h08);
        chk("bs_we", 32'(mem_we), 32'd1);
        chk("bs_addr", 32'(mem_addr), 32'd1);
        chk("bs_di", 32'(mem_di), 32'h7E);
        chk("bs_cursor", 32'(cursor), 32'd1);

        // CR and discard
        for (int i = 0; i < 4; i++) send(8'h61);
        chk("cr_pre", 32'(cursor), 32'd5);
        send(8'h0D);
        chk("cr5_cursor", 32'(cursor), 32'd16);
        chk("cr5_we", 32'(mem_we), 32'd0);
        send(8'h0D);
        chk("cr16_cursor", 32'(cursor), 32'd32);
        for (int i = 0; i < 5; i++) send(8'h0D);
        chk("cr_pre112", 32'(cursor), 32'd112);
        send(8'h0D);
        chk("cr112_cursor", 32'(cursor), 32'd0);
        send(8'h07);
        chk("bel_we", 32'(mem_we), 32'd0);
        send(8'hFF);
        chk("ff_we", 32'(mem_we), 32'd0);
        chk("disc_cursor", 32'(cursor), 32'd0);

        // Clear with stalled input
        send(8'h0C);
        in_data = 8'h41; in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("clr_we", 32'(mem_we), 32'd1);
            chk("clr_addr", 32'(mem_addr), 32'(i));
            chk("clr_di", 32'(mem_di), 32'h7E);
            chk("clr_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("clr_end_ready", 32'(in_ready), 32'd1);
        chk("clr_end_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("post_clr_addr", 32'(mem_addr), 32'd0);
        chk("post_clr_di", 32'(mem_di), 32'h41);
        chk("post_clr_we", 32'(mem_we), 32'd1);

        // Reset mid-clear at the 40th clear cycle
        send(8'h0C);
        idle(39);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_we", 32'(mem_we), 32'd0);
        chk("mid_cursor", 32'(cursor), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(in_ready), 32'd1);
        send(8'h41);
        chk("mid_a_addr", 32'(mem_addr), 32'd0);
        chk("mid_a_di", 32'(mem_di), 32'h41);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int k;
            logic [7:0] b;
            k = int'($urandom_range(0, 99));
            if (k < 55)      b = 8'($urandom_range(32, 126));
            else if (k < 68) b = 8'h08;
            else if (k < 80) b = 8'h0D;
            else if (k < 82) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 2)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            send(b);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_writer.md
# text_writer

Upstream write controller for the 128×8 character display memory. Accepts a byte stream (keyboard/UART decoder output) over a valid/ready handshake, keeps a cursor, and turns each byte into at most one memory write, or into a 128-cycle clear sequence. Drives the memory's `we`/`addr`/`di` port directly; the memory's own reset fill (`8'h7E`) matches this block's reset state.

## Interface
- `DEPTH`, 128: number of memory cells; the cursor wraps modulo `DEPTH`.
- `COLS`, 16: line length used by carriage return; must divide `DEPTH`.
- `FILL`, 8'h7E: blank character written by backspace and clear.
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_data` in 8: incoming character or control code.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block can accept a byte; a byte transfers when `in_valid && in_ready` at a rising edge.
- `mem_we` out 1: write strobe to the memory `we`.
- `mem_addr` out 8: to the memory `addr`.
- `mem_di` out 8: to the memory `di`.
- `cursor` out 8: current cursor position, in the range 0..DEPTH-1.

## Operation
- States: IDLE and CLEAR.
- Reset values: state IDLE, `cursor`=0, `mem_we`=0, `mem_addr`=0, `mem_di`=0. `in_ready` is 0 while `rst` is high.
- `in_ready` = (state==IDLE) && !rst.
- `mem_we`, `mem_addr` and `mem_di` are registered. `mem_we` is a one-cycle pulse per write. When `mem_we`=0, `mem_addr` keeps its last value.
- Byte classes, applied on transfer in IDLE:
  - **Printable, 0x20–0x7E:** write `in_data` at `cursor`. Then `cursor` ← (`cursor`+1) mod `DEPTH`, so 127 wraps to 0.
  - **0x08 BS:**
    - If `cursor`>0: `cursor` ← `cursor`−1, and write `FILL` at the new `cursor`.
    - If `cursor`==0: no write, no move.
  - **0x0D CR:** `cursor` ← ((`cursor`/`COLS`)+1)·`COLS` mod `DEPTH`. This always advances a full line, including when already at a line start. No write.
  - **0x0C FF:** enter CLEAR. Write `FILL` to addresses 0,1,…,DEPTH-1 on consecutive cycles. `cursor` is 0 from the first clear cycle onward. Return to IDLE after address `DEPTH`-1 is issued.
  - **All other codes** (0x00–0x1F except those above, and 0x7F–0xFF): consumed and discarded; no write, no cursor change.
- In CLEAR, `in_valid` is ignored; the byte is held by the source, because `in_ready`=0.
- `rst` asserted mid-CLEAR aborts immediately. The next cycle shows reset values. There is no partial-clear resume; the memory resets to `FILL` on the same `rst`.

## Timing
- Transfer at edge E (end of cycle T). If a write results, `mem_we`=1 with final `mem_addr`/`mem_di` during cycle T+1. The memory captures it at the end of T+1.
- `cursor` updates at E and is visible in T+1.
- Throughput in IDLE is one byte per cycle, back-to-back with no bubble. Consecutive printables produce `mem_we` high on consecutive cycles.
- FF transferred at end of T:
  - `mem_we`=1 during T+1…T+DEPTH, with `mem_addr` = 0…DEPTH-1 and `mem_di`=`FILL`.
  - `in_ready`=0 during T+1…T+DEPTH.
  - `in_ready`=1 in T+DEPTH+1.
  - `mem_we`=0 in T+DEPTH+1 unless a new byte was transferred at the end of T+DEPTH. That cannot happen, since `in_ready` is 0 in T+DEPTH.
- A byte presented with `in_valid`=1 while `in_ready`=0 is not consumed. It must be held and transfers on the first cycle with `in_ready`=1.
- Cursor arithmetic is 8-bit, with explicit wrap at `DEPTH`. No value ≥ `DEPTH` is ever visible on `cursor` or `mem_addr`.

## Test plan
- **Reset then "AB":** `rst` 2 cycles, then 0x41 and 0x42 back-to-back → `mem_we` on 2 consecutive cycles with (addr 0, 0x41) then (addr 1, 0x42); `cursor`=2; `in_ready` stays 1.
- **Wrap:** write 128 printables (0x30 repeated) → last write at addr 127; `cursor`=0; the 129th byte 0x31 is written at addr 0.
- **Backspace:**
  - At `cursor`=0, send 0x08 → no `mem_we`, `cursor` stays 0.
  - After "XY", send 0x08 → one write (addr 1, 0x7E); `cursor`=1.
- **CR and discard:**
  - At `cursor`=5, send 0x0D → `cursor`=16, no write.
  - At `cursor`=16, send 0x0D → `cursor`=32.
  - At `cursor`=112, send 0x0D → `cursor`=0.
  - Send 0x07 and 0xFF → no write, no cursor change.
- **Clear with stalled input:**
  - Send 0x0C, then hold `in_valid`=1 with 0x41 → exactly 128 writes of 0x7E at addrs 0..127 on consecutive cycles, and `in_ready`=0 for 128 cycles.
  - Then 0x41 is written at addr 0, in the cycle after the transfer.
- **Reset mid-clear:** assert `rst` at the 40th clear cycle → next cycle `mem_we`=0, `cursor`=0, state IDLE. After `rst` falls, `in_ready`=1 and 0x41 is written at addr 0.
